// File: rtl/eth_mac_tx_framer.sv
// Byte-wide Ethernet II transmit framer: preamble, SFD, header, payload,
// zero pad and FCS on a GMII-style bus, followed by the inter-frame gap.
module eth_mac_tx_framer #(
    parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_01_FE_C0,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          IFG_BYTES   = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_start,
    input  logic [15:0] tx_len,
    input  logic [47:0] dst_mac,
    input  logic [15:0] eth_type,
    output logic        data_req,
    input  logic [7:0]  data_in,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_err,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        crc_init,
    output logic        crc_en,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_result
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        HEADER,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } state_t;

    localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES);

    state_t       state;
    logic [15:0]  cnt;
    logic [15:0]  len;
    logic [111:0] hdr;
    logic [7:0]   next_byte;
    logic         next_en;
    logic [15:0]  len_last;
    logic [15:0]  pad_last;
    logic         len_ok;

    assign len_last = len - 16'd1;
    assign pad_last = MIN_LEN - len - 16'd1;
    assign len_ok   = (tx_len != 16'd0) && (tx_len <= MAX_LEN);

    // Next-byte mux: this is the D input of gmii_txd and also the CRC byte.
    always_comb begin
        next_byte = 8'h00;
        next_en   = 1'b0;
        crc_en    = 1'b0;
        unique case (state)
            PREAMBLE: begin
                next_byte = 8'h55;
                next_en   = 1'b1;
            end
            SFD: begin
                next_byte = 8'hD5;
                next_en   = 1'b1;
            end
            HEADER: begin
                next_byte = hdr[111:104];
                next_en   = 1'b1;
                crc_en    = 1'b1;
            end
            PAYLOAD: begin
                next_byte = data_in;
                next_en   = 1'b1;
                crc_en    = 1'b1;
            end
            PAD: begin
                next_byte = 8'h00;
                next_en   = 1'b1;
                crc_en    = 1'b1;
            end
            FCS: begin
                next_en = 1'b1;
                unique case (cnt[1:0])
                    2'd0: next_byte = crc_result[7:0];
                    2'd1: next_byte = crc_result[15:8];
                    2'd2: next_byte = crc_result[23:16];
                    2'd3: next_byte = crc_result[31:24];
                    default: next_byte = 8'h00;
                endcase
            end
            default: begin
                next_byte = 8'h00;
            end
        endcase
    end

    assign crc_data = next_byte;
    assign crc_init = (state == SFD);

    // Upstream read leads the payload mux by one cycle to cover FIFO latency.
    assign data_req = ((state == HEADER) && (cnt == 16'd13))
                   || ((state == PAYLOAD) && (cnt != len_last));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            len        <= 16'd0;
            hdr        <= '0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            gmii_txd   <= next_byte;
            gmii_tx_en <= next_en;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_start && len_ok) begin
                        len     <= tx_len;
                        hdr     <= {dst_mac, SRC_MAC, eth_type};
                        tx_busy <= 1'b1;
                        cnt     <= 16'd0;
                        state   <= PREAMBLE;
                    end else if (tx_start) begin
                        tx_err <= 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (cnt == 16'd6) begin
                        cnt   <= 16'd0;
                        state <= SFD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SFD: begin
                    cnt   <= 16'd0;
                    state <= HEADER;
                end
                HEADER: begin
                    hdr <= {hdr[103:0], 8'h00};
                    if (cnt == 16'd13) begin
                        cnt   <= 16'd0;
                        state <= PAYLOAD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PAYLOAD: begin
                    if (cnt == len_last) begin
                        cnt   <= 16'd0;
                        state <= (len < MIN_LEN) ? PAD : FCS;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PAD: begin
                    if (cnt == pad_last) begin
                        cnt   <= 16'd0;
                        state <= FCS;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FCS: begin
                    if (cnt == 16'd3) begin
                        cnt   <= 16'd0;
                        state <= IFG;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                IFG: begin
                    // First IFG cycle still shows the last FCS byte on the bus.
                    if (cnt == IFG_LAST) begin
                        cnt     <= 16'd0;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (cnt == IFG_LAST - 16'd1) begin
                            tx_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
